// File: rtl/board_gpio_bank_if.sv
// Peripheral-side bundle of the GPIO bank: data/direction from the SoC GPIO
// block, conditioned input back to it, and edge-capture control/status.
interface board_gpio_bank_if #(
    parameter int N_CH = 16
);
    logic [N_CH-1:0] gpio_out_i;
    logic [N_CH-1:0] gpio_dir_i;
    logic [N_CH-1:0] gpio_in_o;
    logic [N_CH-1:0] db_en_i;
    logic [N_CH-1:0] rise_en_i;
    logic [N_CH-1:0] fall_en_i;
    logic [N_CH-1:0] edge_clr_i;
    logic [N_CH-1:0] edge_status_o;
    logic            irq_o;

    // SoC GPIO peripheral side
    modport master (
        output gpio_out_i, gpio_dir_i, db_en_i, rise_en_i, fall_en_i, edge_clr_i,
        input  gpio_in_o, edge_status_o, irq_o
    );

    // Pad bank side
    modport slave (
        input  gpio_out_i, gpio_dir_i, db_en_i, rise_en_i, fall_en_i, edge_clr_i,
        output gpio_in_o, edge_status_o, irq_o
    );
endinterface

// File: rtl/board_gpio_bank.sv
// Pad-side GPIO bank: registered tristate outputs, input synchronisers,
// optional per-channel debounce and sticky rise/fall capture with one IRQ.
// The input path ignores direction, so driven pins still read back.
module board_gpio_bank #(
    parameter int N_CH            = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   pad_i,
    output logic [N_CH-1:0]   pad_o,
    output logic [N_CH-1:0]   pad_oe,
    board_gpio_bank_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [N_CH-1:0] stable_q;
    logic [N_CH-1:0] stable_d_q;
    logic [N_CH-1:0] status_q;
    logic [N_CH-1:0] edge_set;

    assign sync = sync_q[SYNC_STAGES-1];

    // Output path: one-cycle registered copy; all pins are inputs in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_o  <= '0;
            pad_oe <= '0;
        end else begin
            pad_o  <= bus.gpio_out_i;
            pad_oe <= bus.gpio_dir_i;
        end
    end

    // Synchroniser chain per pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= pad_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
    // differing cycles; any matching cycle or disabled channel zeroes the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!bus.db_en_i[i]) begin
                    stable_q[i] <= sync[i];
                    cnt_q[i]    <= '0;
                end else if (sync[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    stable_q[i] <= sync[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Qualified edges of the accepted level.
    always_comb begin
        edge_set = (stable_q & ~stable_d_q & bus.rise_en_i)
                 | (~stable_q & stable_d_q & bus.fall_en_i);
    end

    // Sticky edge flags; a new edge wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d_q <= '0;
            status_q   <= '0;
        end else begin
            stable_d_q <= stable_q;
            status_q   <= edge_set | (status_q & ~bus.edge_clr_i);
        end
    end

    assign bus.gpio_in_o     = stable_q;
    assign bus.edge_status_o = status_q;
    assign bus.irq_o         = |status_q;
endmodule

// File: tb/tb_board_gpio_bank.sv
// Directed bench for board_gpio_bank with N_CH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Inputs change and outputs are observed 1 ns after
// each rising edge.
module tb_board_gpio_bank;
    localparam int N_CH = 4;

    logic            clk;
    logic            rst_n;
    logic [N_CH-1:0] pad_i;
    logic [N_CH-1:0] pad_o;
    logic [N_CH-1:0] pad_oe;

    int total;
    int bad;

    board_gpio_bank_if #(.N_CH(N_CH)) bus ();

    board_gpio_bank #(
        .N_CH(N_CH),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pad_i(pad_i),
        .pad_o(pad_o),
        .pad_oe(pad_oe),
        .bus(bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n            = 1'b0;
        pad_i            = 4'hF;
        bus.gpio_out_i   = 4'hF;
        bus.gpio_dir_i   = 4'hF;
        bus.db_en_i      = 4'h0;
        bus.rise_en_i    = 4'hF;
        bus.fall_en_i    = 4'h0;
        bus.edge_clr_i   = 4'h0;
        step(4);
        total++; if (pad_oe !== 4'h0) begin bad++; $display("FAIL reset_pad_oe got=%h exp=0", pad_oe); end
        total++; if (pad_o !== 4'h0) begin bad++; $display("FAIL reset_pad_o got=%h exp=0", pad_o); end
        total++; if (bus.gpio_in_o !== 4'h0) begin bad++; $display("FAIL reset_gpio_in got=%h exp=0", bus.gpio_in_o); end
        total++; if (bus.irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", bus.irq_o); end
        total++; if (bus.edge_status_o !== 4'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", bus.edge_status_o); end
        rst_n = 1'b1;
        step(2);
        total++; if (bus.gpio_in_o !== 4'h0) begin bad++; $display("FAIL release_in_early got=%h exp=0", bus.gpio_in_o); end
        step(1);
        total++; if (bus.gpio_in_o !== 4'hF) begin bad++; $display("FAIL release_in got=%h exp=f", bus.gpio_in_o); end
        total++; if (bus.edge_status_o !== 4'h0) begin bad++; $display("FAIL release_status_early got=%h exp=0", bus.edge_status_o); end
        step(1);
        total++; if (bus.edge_status_o !== 4'hF) begin bad++; $display("FAIL release_status got=%h exp=f", bus.edge_status_o); end
        total++; if (bus.irq_o !== 1'b1) begin bad++; $display("FAIL release_irq got=%b exp=1", bus.irq_o); end
        // Return all pins low and clear the flags.
        bus.rise_en_i = 4'h0;
        pad_i = 4'h0;
        step(5);
        bus.edge_clr_i = 4'hF;
        step(1);
        bus.edge_clr_i = 4'h0;
        total++; if (bus.edge_status_o !== 4'h0 || bus.irq_o !== 1'b0) begin
            bad++; $display("FAIL release_clear status=%h irq=%b exp=0/0", bus.edge_status_o, bus.irq_o);
        end
    endtask

    task automatic test_output_path;
        bus.gpio_dir_i = 4'b0101;
        bus.gpio_out_i = 4'b0001;
        #1;
        total++; if (pad_oe !== 4'hF) begin bad++; $display("FAIL out_latency_oe got=%h exp=f", pad_oe); end
        step(1);
        total++; if (pad_oe !== 4'b0101) begin bad++; $display("FAIL out_oe got=%b exp=0101", pad_oe); end
        total++; if (pad_o !== 4'b0001) begin bad++; $display("FAIL out_o got=%b exp=0001", pad_o); end
        bus.gpio_dir_i = 4'b1010;
        bus.gpio_out_i = 4'b1110;
        step(1);
        total++; if (pad_oe !== 4'b1010) begin bad++; $display("FAIL out_oe2 got=%b exp=1010", pad_oe); end
        total++; if (pad_o !== 4'b1110) begin bad++; $display("FAIL out_o2 got=%b exp=1110", pad_o); end
    endtask

    task automatic test_debounce_accept;
        bus.db_en_i   = 4'b0001;
        bus.rise_en_i = 4'b0001;
        pad_i         = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            step(1);
            total++; if (bus.gpio_in_o[0] !== 1'b0) begin bad++; $display("FAIL db_early cycle=%0d got=%b exp=0", c, bus.gpio_in_o[0]); end
        end
        step(1);
        total++; if (bus.gpio_in_o[0] !== 1'b1) begin bad++; $display("FAIL db_accept got=%b exp=1", bus.gpio_in_o[0]); end
        step(1);
        total++; if (bus.edge_status_o !== 4'b0001 || bus.irq_o !== 1'b1) begin
            bad++; $display("FAIL db_rise status=%b irq=%b exp=0001/1", bus.edge_status_o, bus.irq_o);
        end
        bus.rise_en_i  = 4'b0000;
        bus.edge_clr_i = 4'b0001;
        step(1);
        bus.edge_clr_i = 4'b0000;
        total++; if (bus.edge_status_o !== 4'b0000 || bus.irq_o !== 1'b0) begin
            bad++; $display("FAIL db_clear status=%b irq=%b exp=0000/0", bus.edge_status_o, bus.irq_o);
        end
        // Debounced return to 0 before the glitch test.
        pad_i = 4'b0000;
        step(8);
        total++; if (bus.gpio_in_o[0] !== 1'b0) begin bad++; $display("FAIL db_release got=%b exp=0", bus.gpio_in_o[0]); end
    endtask

    task automatic test_glitch_reject;
        bus.db_en_i   = 4'b0001;
        bus.rise_en_i = 4'b0001;
        pad_i         = 4'b0001;
        step(3);
        pad_i = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            step(1);
            total++; if (bus.gpio_in_o[0] !== 1'b0 || bus.edge_status_o[0] !== 1'b0) begin
                bad++; $display("FAIL glitch cycle=%0d in=%b status=%b exp=0/0", c, bus.gpio_in_o[0], bus.edge_status_o[0]);
            end
        end
        bus.rise_en_i = 4'b0000;
        bus.db_en_i   = 4'b0000;
    endtask

    task automatic test_fall_capture;
        bus.fall_en_i = 4'b0010;
        bus.rise_en_i = 4'b0000;
        pad_i         = 4'b0010;
        step(3);
        total++; if (bus.gpio_in_o !== 4'b0010) begin bad++; $display("FAIL fall_rise_in got=%b exp=0010", bus.gpio_in_o); end
        step(1);
        total++; if (bus.edge_status_o !== 4'b0000 || bus.irq_o !== 1'b0) begin
            bad++; $display("FAIL fall_no_rise status=%b irq=%b exp=0000/0", bus.edge_status_o, bus.irq_o);
        end
        pad_i = 4'b0000;
        step(3);
        total++; if (bus.edge_status_o !== 4'b0000) begin bad++; $display("FAIL fall_early status=%b exp=0000", bus.edge_status_o); end
        step(1);
        total++; if (bus.edge_status_o !== 4'b0010 || bus.irq_o !== 1'b1) begin
            bad++; $display("FAIL fall_set status=%b irq=%b exp=0010/1", bus.edge_status_o, bus.irq_o);
        end
        step(2);
        total++; if (bus.edge_status_o !== 4'b0010) begin bad++; $display("FAIL fall_sticky status=%b exp=0010", bus.edge_status_o); end
        bus.edge_clr_i = 4'b0010;
        step(1);
        bus.edge_clr_i = 4'b0000;
        total++; if (bus.edge_status_o !== 4'b0000 || bus.irq_o !== 1'b0) begin
            bad++; $display("FAIL fall_clear status=%b irq=%b exp=0000/0", bus.edge_status_o, bus.irq_o);
        end
        bus.fall_en_i = 4'b0000;
    endtask

    task automatic test_set_clear_collision;
        bus.rise_en_i = 4'b0100;
        pad_i         = 4'b0100;
        step(3);
        // Flag sets on the next edge; clear arrives on the same edge.
        bus.edge_clr_i = 4'b0100;
        step(1);
        bus.edge_clr_i = 4'b0000;
        total++; if (bus.edge_status_o[2] !== 1'b1 || bus.irq_o !== 1'b1) begin
            bad++; $display("FAIL collide status2=%b irq=%b exp=1/1", bus.edge_status_o[2], bus.irq_o);
        end
        step(1);
        total++; if (bus.edge_status_o !== 4'b0100 || bus.irq_o !== 1'b1) begin
            bad++; $display("FAIL collide_hold status=%b irq=%b exp=0100/1", bus.edge_status_o, bus.irq_o);
        end
        bus.edge_clr_i = 4'b0100;
        step(1);
        bus.edge_clr_i = 4'b0000;
        total++; if (bus.edge_status_o !== 4'b0000 || bus.irq_o !== 1'b0) begin
            bad++; $display("FAIL collide_clear status=%b irq=%b exp=0000/0", bus.edge_status_o, bus.irq_o);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_output_path();
        test_debounce_accept();
        test_glitch_reject();
        test_fall_capture();
        test_set_clear_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
